// File: rtl/rv32_mem_arbiter_pkg.sv
// Shared definitions for the rv32 instruction/data memory arbiter.
//  - arb_state_e : arbiter sequencing states (IDLE -> ISSUE -> WAIT)
//  - owner_e     : which requester owns the transaction in flight
//  - cnt_width() : width of a counter that must hold 0..max_val (never 0 bits)
package rv32_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 32'd1);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/rv32_mem_arbiter_pick.sv
// Combinational arbitration between fetch and data requests.
// Data wins by default; fetch wins when data is idle or when the starvation
// counter has reached STARVE_MAX.
// Ports:
//  if_req_i     fetch request
//  d_req_i      data request
//  starve_cnt_i consecutive data wins while fetch was waiting
//  pick_if_o    fetch selected
//  pick_d_o     data selected (never together with pick_if_o)
module rv32_arb_pick #(
    parameter int STARVE_MAX = 4,
    parameter int CW         = 3
) (
    input  logic          if_req_i,
    input  logic          d_req_i,
    input  logic [CW-1:0] starve_cnt_i,
    output logic          pick_if_o,
    output logic          pick_d_o
);

    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic starved;

    assign starved   = (starve_cnt_i == STARVE_LIM);
    assign pick_if_o = if_req_i & (~d_req_i | starved);
    assign pick_d_o  = d_req_i & ~pick_if_o;

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Arbiter sharing one single-port memory between the rv32 fetch port and
// load/store port. One transaction at a time, sequenced grant -> issue ->
// (read wait). Grants are combinational in IDLE; all mem_* outputs are
// registered.
// Ports:
//  clk_i, reset_i                 clock, synchronous active-high reset
//  if_req_i/if_addr_i             fetch request and address
//  if_gnt_o/if_rvalid_o/if_rdata_o fetch grant, read-data strobe and data
//  d_req_i/d_we_i/d_addr_i/d_wdata_i data request, store flag, address, data
//  d_gnt_o/d_rvalid_o/d_rdata_o   data grant, load-data strobe and data
//  mem_addr_o/mem_rd_o/mem_wr_o/mem_wdata_o/mem_rdata_i  memory side
module rv32_mem_arbiter
    import rv32_mem_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_rd_o,
    output logic          mem_wr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int CW = int'(cnt_width(STARVE_MAX));
    localparam int LW = int'(cnt_width(MEM_LAT - 1));
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
    // WAIT lasts MEM_LAT cycles: the counter runs MEM_LAT-1 down to 0.
    localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT - 1);

    arb_state_e    state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [LW-1:0] lat_q, lat_d;

    logic pick_if, pick_d;
    logic gnt_if, gnt_d;
    logic rvalid_if, rvalid_d;

    rv32_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CW         (CW)
    ) u_pick (
        .if_req_i     (if_req_i),
        .d_req_i      (d_req_i),
        .starve_cnt_i (starve_q),
        .pick_if_o    (pick_if),
        .pick_d_o     (pick_d)
    );

    // Next-state, grant and read-valid logic for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        starve_d    = starve_q;
        lat_d       = lat_q;
        gnt_if      = 1'b0;
        gnt_d       = 1'b0;
        rvalid_if   = 1'b0;
        rvalid_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_if) begin
                    gnt_if     = 1'b1;
                    owner_d    = OWN_IF;
                    we_d       = 1'b0;
                    mem_addr_d = if_addr_i;
                    mem_rd_d   = 1'b1;
                    starve_d   = '0;
                    state_d    = ST_ISSUE;
                end else if (pick_d) begin
                    gnt_d       = 1'b1;
                    owner_d     = OWN_D;
                    we_d        = d_we_i;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                    mem_rd_d    = ~d_we_i;
                    mem_wr_d    = d_we_i;
                    // Only data wins that made fetch wait count toward starvation.
                    if (if_req_i && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + CW'(1);
                    end else begin
                        starve_d = starve_q;
                    end
                    state_d     = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    owner_d = OWN_NONE;
                    state_d = ST_IDLE;
                end else begin
                    lat_d   = LAT_LAST;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    rvalid_if = (owner_q == OWN_IF);
                    rvalid_d  = (owner_q == OWN_D);
                    owner_d   = OWN_NONE;
                    state_d   = ST_IDLE;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            default: begin
                owner_d = OWN_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and memory-side registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            starve_q    <= '0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            starve_q    <= starve_d;
            lat_q       <= lat_d;
        end
    end

    // Handshake outputs are suppressed while reset is asserted, so an
    // abandoned read never reports data.
    assign if_gnt_o    = gnt_if & ~reset_i;
    assign d_gnt_o     = gnt_d & ~reset_i;
    assign if_rvalid_o = rvalid_if & ~reset_i;
    assign d_rvalid_o  = rvalid_d & ~reset_i;
    assign if_rdata_o  = mem_rdata_i;
    assign d_rdata_o   = mem_rdata_i;

    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_rd_o    = mem_rd_q;
    assign mem_wr_o    = mem_wr_q;

endmodule
